// File: rtl/dps_strap_mux_if.sv
// Pad-side and core-side signals of the debug-port strap mux.
// The master modport belongs to dps_strap_mux; slave is the surrounding top level.
interface dps_strap_mux_if;
  logic pad_clk_i;
  logic pad_sel_i;
  logic pad_din_i;
  logic pad_trst_ni;
  logic pad_srst_ni;
  logic pad_dout_o;
  logic pad_dout_oe_o;
  logic jtag_tck_o;
  logic jtag_tms_o;
  logic jtag_tdi_o;
  logic jtag_trst_no;
  logic jtag_srst_no;
  logic jtag_tdo_i;
  logic spi_sck_o;
  logic spi_csb_o;
  logic spi_mosi_o;
  logic spi_miso_i;
  logic spi_miso_en_i;

  modport master (
    input  pad_clk_i, pad_sel_i, pad_din_i, pad_trst_ni, pad_srst_ni,
    input  jtag_tdo_i, spi_miso_i, spi_miso_en_i,
    output pad_dout_o, pad_dout_oe_o,
    output jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no, jtag_srst_no,
    output spi_sck_o, spi_csb_o, spi_mosi_o
  );

  modport slave (
    output pad_clk_i, pad_sel_i, pad_din_i, pad_trst_ni, pad_srst_ni,
    output jtag_tdo_i, spi_miso_i, spi_miso_en_i,
    input  pad_dout_o, pad_dout_oe_o,
    input  jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no, jtag_srst_no,
    input  spi_sck_o, spi_csb_o, spi_mosi_o
  );
endinterface

// File: rtl/dps_strap_mux.sv
// Strap sampler with settle/debounce/lock, and a combinational DPS pad mux
// that routes the shared pads to the JTAG TAP or the spi_device once locked.
module dps_strap_mux #(
  parameter int unsigned NumStraps      = 2,
  parameter int unsigned SettleCycles   = 4,
  parameter int unsigned DebounceCycles = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumStraps-1:0] strap_i,
  input  logic                 resample_i,
  dps_strap_mux_if.master      dps,
  output logic [NumStraps-1:0] strap_o,
  output logic                 strap_valid_o,
  output logic                 mode_spi_o,
  output logic [1:0]           dbg_state_o
);
  localparam int unsigned MaxCycles =
    (SettleCycles > DebounceCycles) ? SettleCycles : DebounceCycles;
  localparam int unsigned CntW = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] SettleLast   = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] DebounceLast = CntW'(DebounceCycles - 1);

  typedef enum logic [1:0] {
    ST_SETTLE   = 2'd0,
    ST_SAMPLE   = 2'd1,
    ST_DEBOUNCE = 2'd2,
    ST_LOCKED   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [NumStraps-1:0] cand_q, cand_d;
  logic [NumStraps-1:0] strap_q, strap_d;
  logic                 locked;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_SETTLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      strap_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      strap_q <= strap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    strap_d = strap_q;
    unique case (state_q)
      ST_SETTLE: begin
        if (cnt_q == SettleLast) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_SAMPLE: begin
        cand_d  = strap_i;
        cnt_d   = '0;
        state_d = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        // Any change restarts the stability window around the new value.
        if (strap_i != cand_q) begin
          cand_d = strap_i;
          cnt_d  = '0;
        end else if (cnt_q == DebounceLast) begin
          strap_d = cand_q;
          cnt_d   = '0;
          state_d = ST_LOCKED;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_LOCKED: begin
        if (resample_i) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  // strap_valid_o is a level qualifier with no ready: strap_o and the pad
  // mux are meaningful exactly while it is high.
  assign locked        = (state_q == ST_LOCKED);
  assign strap_valid_o = locked;
  assign strap_o       = strap_q;
  assign mode_spi_o    = strap_q[0];
  assign dbg_state_o   = state_q;

  // Pad paths stay combinational so TCK/SCK edges are never retimed.
  always_comb begin
    dps.jtag_tck_o    = 1'b0;
    dps.jtag_tms_o    = 1'b1;
    dps.jtag_tdi_o    = 1'b0;
    dps.jtag_trst_no  = 1'b0;
    dps.jtag_srst_no  = 1'b1;
    dps.spi_sck_o     = 1'b0;
    dps.spi_csb_o     = 1'b1;
    dps.spi_mosi_o    = 1'b0;
    dps.pad_dout_o    = 1'b0;
    dps.pad_dout_oe_o = 1'b0;
    if (locked) begin
      if (!strap_q[0]) begin
        dps.jtag_tck_o    = dps.pad_clk_i;
        dps.jtag_tms_o    = dps.pad_sel_i;
        dps.jtag_tdi_o    = dps.pad_din_i;
        dps.jtag_trst_no  = dps.pad_trst_ni;
        dps.jtag_srst_no  = dps.pad_srst_ni;
        dps.pad_dout_o    = dps.jtag_tdo_i;
        dps.pad_dout_oe_o = 1'b1;
      end else begin
        dps.spi_sck_o     = dps.pad_clk_i;
        dps.spi_csb_o     = dps.pad_sel_i;
        dps.spi_mosi_o    = dps.pad_din_i;
        dps.pad_dout_o    = dps.spi_miso_i;
        dps.pad_dout_oe_o = dps.spi_miso_en_i;
      end
    end
  end
endmodule
